hall_speed_estimator: RTL
=========================

HALL_SPEED_ESTIMATOR -- requirements
Module: hall_speed_estimator

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: consecutive stable cycles before a hall code is accepted.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 20: width of the step-interval counter and the period output.
REQ-003 SHALL have parameter POS_WIDTH, default 16: width of the signed step position.
REQ-004 SHALL have parameter STALL_TIMEOUT, default 'hFFFFF: cycles without a step before stall is declared; must be at most 2^PERIOD_WIDTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port hall, input, 3 bits: raw asynchronous hall sensor lines.
REQ-008 SHALL have port position, output, POS_WIDTH bits: signed commutation step count.
REQ-009 SHALL have port direction, output, 1 bit: 0 is forward, 1 is reverse, for the last step.
REQ-010 SHALL have port period, output, PERIOD_WIDTH bits: clk cycles between the last two steps.
REQ-011 SHALL have port period_valid, output, 1 bit: period is a trustworthy measurement.
REQ-012 SHALL have port stalled, output, 1 bit: no step seen within STALL_TIMEOUT.
REQ-013 SHALL have port step_strobe, output, 1 bit: one-cycle pulse per valid step.
REQ-014 SHALL have port hall_err, output, 1 bit: one-cycle pulse per invalid code or skipped step.

Function
REQ-015 SHALL pass hall through a 2-flop synchronizer before any other logic.
REQ-016 SHALL map codes to sector indices: 001=0, 011=1, 010=2, 110=3, 100=4, 101=5.
REQ-017 SHALL treat 000 and 111 as invalid: on acceptance, pulse hall_err for one cycle, leave position unchanged, and do not update the last valid sector.
REQ-018 SHALL, for the first valid sector after reset, record the sector only; no step_strobe and no hall_err.
REQ-019 SHALL compute delta = (new - last) mod 6: 1 is a forward step, 5 is a reverse step, and 2, 3 or 4 is a skip.
REQ-020 SHALL, on a skip: pulse hall_err, update the last sector, clear period_valid, restart the interval counter, and not pulse step_strobe.
REQ-021 SHALL, on a step, in the cycle after acceptance: pulse step_strobe, add 1 to position (forward) or subtract 1 (reverse) with two's-complement wrap, and update direction.
REQ-022 SHALL count cycles since the last step or skip, saturating at 2^PERIOD_WIDTH-1; on a step, latch the count into period and reset the count to 0.
REQ-023 SHALL set period_valid on a step only if the previous event was a step in the same direction with stalled=0; otherwise clear it.
REQ-024 SHALL, when the count reaches STALL_TIMEOUT: set stalled=1 and clear period_valid, with period holding its value.
REQ-025 SHALL clear stalled on the next step; period_valid becomes valid again no earlier than the second step after the stall.
REQ-026 SHALL have a latency from hall pin to step_strobe of 2 + FILTER_CYCLES + 1 cycles with the filter, or 3 cycles without it.
REQ-027 SHALL give a step precedence over stall timeout when both occur in the same cycle.

Reset
REQ-028 SHALL, under rst, set position=0, direction=0, period=0, period_valid=0, stalled=1, step_strobe=0, hall_err=0, the counter to 0, and the last sector to none.
REQ-029 SHALL have rst asserted mid-operation take effect on the next clk edge; the first valid code after release is treated per REQ-018.

Configuration
REQ-030 SHALL use macro HALL_GLITCH_FILTER_EN to select input filtering.
- Defined: a synchronized code is accepted only after it is stable for FILTER_CYCLES consecutive cycles.
- Undefined: every synchronized code change is accepted immediately and FILTER_CYCLES is ignored.

Structure
REQ-031 SHALL place the sector lookup constants, the invalid-code constants and the direction encoding in a shared package, hall_pkg.
REQ-032 SHALL implement the synchronizer and filter as the sub-module hall_input_filter; sector decoding, position, period and stall logic stay in the top module.

Verification
REQ-033 SHALL test forward stepping: sequence 001,011,010,110,100,101 at 1000-cycle spacing -> position +1 per step, direction=0, period=1000, period_valid=1 from the third code.
REQ-034 SHALL test reverse stepping: reversed sequence after 12 forward steps -> position decrements from 12, the first reverse step has period_valid=0, and later ones have period_valid=1.
REQ-035 SHALL test an invalid code: 111 held 50 cycles, then 011 after 001 -> exactly one hall_err, position unchanged across 111, then a +1 step.
REQ-036 SHALL test a skip and a stall: 001 to 010 gives hall_err with no step_strobe; then no change for STALL_TIMEOUT gives stalled=1 and period_valid=0; the next step clears stalled with period_valid=0.
REQ-037 SHALL test the glitch filter: a 2-cycle 011 glitch on 001 -> with HALL_GLITCH_FILTER_EN, nothing happens; without it, a step followed by a reverse step.
REQ-038 SHALL test wrap and reset: position at 32767 plus a forward step gives -32768; rst mid-sequence restores all reset values, and the next code gives no strobe.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared definitions for the hall speed estimator.
//   - Hall code constants for the six valid sectors and the two invalid codes
//   - Sector encoding (0..5, plus a "none" marker used before the first valid code)
//   - Direction encoding for the direction output
//   - Helper functions: code-to-sector lookup, invalid-code test, step classification
package hall_pkg;

    // Raw hall codes in commutation order (forward rotation walks S0 -> S5).
    localparam logic [2:0] HALL_S0 = 3'b001;
    localparam logic [2:0] HALL_S1 = 3'b011;
    localparam logic [2:0] HALL_S2 = 3'b010;
    localparam logic [2:0] HALL_S3 = 3'b110;
    localparam logic [2:0] HALL_S4 = 3'b100;
    localparam logic [2:0] HALL_S5 = 3'b101;

    // Codes a healthy sensor never produces (all lines low / all lines high).
    localparam logic [2:0] HALL_INV_LO = 3'b000;
    localparam logic [2:0] HALL_INV_HI = 3'b111;

    // Value the input pipeline holds out of reset.
    localparam logic [2:0] HALL_IDLE = HALL_INV_LO;

    // Sector index marker meaning "no valid sector seen yet".
    localparam logic [2:0] SECTOR_NONE = 3'd7;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_SKIP
    } step_kind_t;

    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        case (code)
            HALL_S0: return 3'd0;
            HALL_S1: return 3'd1;
            HALL_S2: return 3'd2;
            HALL_S3: return 3'd3;
            HALL_S4: return 3'd4;
            HALL_S5: return 3'd5;
            default: return SECTOR_NONE;
        endcase
    endfunction

    function automatic logic is_invalid_code(input logic [2:0] code);
        return (code == HALL_INV_LO) || (code == HALL_INV_HI);
    endfunction

    // delta = (to - from) mod 6, computed without a divider: both inputs are 0..5,
    // so to + 6 - from lies in 1..11 and one conditional subtract folds it back.
    function automatic step_kind_t classify_step(input logic [2:0] from_s,
                                                 input logic [2:0] to_s);
        logic [3:0] diff;
        diff = {1'b0, to_s} + 4'd6 - {1'b0, from_s};
        if (diff >= 4'd6) begin
            diff = diff - 4'd6;
        end
        case (diff)
            4'd0:    return STEP_NONE;
            4'd1:    return STEP_FWD;
            4'd5:    return STEP_REV;
            default: return STEP_SKIP;
        endcase
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Hall input conditioning: 2-flop synchronizer followed by an optional
// stability filter. Emits a one-cycle accept pulse with the accepted code
// whenever the conditioned code changes.
// Configuration macro: HALL_GLITCH_FILTER_EN
//   defined   -> a code is accepted only after FILTER_CYCLES stable cycles
//   undefined -> every synchronized change is accepted at once
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   hall_raw[2:0]: asynchronous hall sensor lines
//   code[2:0]   : accepted code (meaningful while accept=1)
//   accept      : one-cycle pulse per newly accepted code
module hall_input_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall_raw,
    output logic [2:0] code,
    output logic       accept
);

`ifdef HALL_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    // Zero depth means changes go straight through once synchronized.
    localparam int unsigned DEPTH =
        FILTER_ON ? ((FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES) : 0;

    logic [2:0] sync1_d, sync1_q;
    logic [2:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = hall_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= HALL_IDLE;
            sync2_q <= HALL_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (DEPTH == 0) begin : g_direct
            logic [2:0] prev_d, prev_q;

            always_comb prev_d = sync2_q;

            always_ff @(posedge clk) begin
                if (rst) prev_q <= HALL_IDLE;
                else     prev_q <= prev_d;
            end

            assign code   = sync2_q;
            assign accept = (sync2_q != prev_q);
        end else begin : g_filter
            localparam int unsigned CNT_W = $clog2(DEPTH + 1);

            logic [2:0]       cand_d, cand_q;
            logic [2:0]       acc_d, acc_q;
            logic [CNT_W-1:0] cnt_d, cnt_q;
            logic             acc_pulse;

            // cand tracks the current synchronized code; cnt counts how long it
            // has been unchanged and saturates at DEPTH so a steady code is
            // accepted exactly once, and only if it differs from the last one.
            always_comb begin
                cand_d    = cand_q;
                cnt_d     = cnt_q;
                acc_d     = acc_q;
                acc_pulse = 1'b0;
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q < CNT_W'(DEPTH)) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q == CNT_W'(DEPTH - 1)) && (cand_q != acc_q)) begin
                        acc_pulse = 1'b1;
                        acc_d     = cand_q;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cand_q <= HALL_IDLE;
                    acc_q  <= HALL_IDLE;
                    cnt_q  <= '0;
                end else begin
                    cand_q <= cand_d;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign code   = cand_q;
            assign accept = acc_pulse;
        end
    endgenerate

endmodule

// File: rtl/hall_speed_estimator.sv
// Hall-sensor speed estimator: decodes accepted hall codes into sectors,
// tracks signed step position and direction, measures the step interval and
// flags stalls and sensor faults.
// Configuration macro: HALL_GLITCH_FILTER_EN (selects input stability filter)
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   hall[2:0]     : raw hall sensor lines
//   position      : signed step count (wraps)
//   direction     : 0 forward, 1 reverse, for the last step
//   period        : cycles between the last two steps
//   period_valid  : period is a trustworthy measurement
//   stalled       : no step within STALL_TIMEOUT cycles
//   step_strobe   : one-cycle pulse per valid step
//   hall_err      : one-cycle pulse per invalid code or skipped step
module hall_speed_estimator
    import hall_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned PERIOD_WIDTH  = 20,
    parameter int unsigned POS_WIDTH     = 16,
    parameter int unsigned STALL_TIMEOUT = 'hFFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  hall,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        direction,
    output logic [PERIOD_WIDTH-1:0]     period,
    output logic                        period_valid,
    output logic                        stalled,
    output logic                        step_strobe,
    output logic                        hall_err
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX  = '1;
    localparam logic [PERIOD_WIDTH-1:0] STALL_LIMIT = PERIOD_WIDTH'(STALL_TIMEOUT);
    localparam logic signed [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0] code;
    logic       accept;

    hall_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .hall_raw(hall),
        .code    (code),
        .accept  (accept)
    );

    logic signed [POS_WIDTH-1:0] position_d, position_q;
    logic                        direction_d, direction_q;
    logic [PERIOD_WIDTH-1:0]     period_d, period_q;
    logic [PERIOD_WIDTH-1:0]     count_d, count_q;
    logic                        period_valid_d, period_valid_q;
    logic                        stalled_d, stalled_q;
    logic                        step_strobe_d, step_strobe_q;
    logic                        hall_err_d, hall_err_q;
    logic [2:0]                  last_sector_d, last_sector_q;
    // Last sector-changing event was a step (as opposed to a skip or reset).
    logic                        prev_step_d, prev_step_q;

    logic [2:0] sector;
    step_kind_t kind;
    logic       new_dir;
    logic       is_step;

    always_comb begin
        sector         = hall_to_sector(code);
        kind           = classify_step(last_sector_q, sector);
        new_dir        = (kind == STEP_REV) ? DIR_REV : DIR_FWD;
        is_step        = 1'b0;
        position_d     = position_q;
        direction_d    = direction_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;
        step_strobe_d  = 1'b0;
        hall_err_d     = 1'b0;
        last_sector_d  = last_sector_q;
        prev_step_d    = prev_step_q;
        count_d        = (count_q == PERIOD_MAX) ? count_q : count_q + 1'b1;

        if (accept) begin
            if (is_invalid_code(code)) begin
                hall_err_d = 1'b1;
            end else if (last_sector_q == SECTOR_NONE) begin
                last_sector_d = sector;
            end else begin
                last_sector_d = sector;
                case (kind)
                    STEP_FWD, STEP_REV: begin
                        is_step        = 1'b1;
                        step_strobe_d  = 1'b1;
                        position_d     = (new_dir == DIR_REV) ? position_q - POS_ONE
                                                              : position_q + POS_ONE;
                        direction_d    = new_dir;
                        // count_q is one short of the edge-to-edge distance.
                        period_d       = (count_q == PERIOD_MAX) ? PERIOD_MAX
                                                                 : count_q + 1'b1;
                        period_valid_d = prev_step_q && (direction_q == new_dir) && !stalled_q;
                        stalled_d      = 1'b0;
                        prev_step_d    = 1'b1;
                        count_d        = '0;
                    end
                    STEP_SKIP: begin
                        hall_err_d     = 1'b1;
                        period_valid_d = 1'b0;
                        prev_step_d    = 1'b0;
                        count_d        = '0;
                    end
                    default: ;
                endcase
            end
        end

        // A step arriving on the timeout cycle wins over the stall.
        if (!is_step && (count_q >= STALL_LIMIT)) begin
            stalled_d      = 1'b1;
            period_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            position_q     <= '0;
            direction_q    <= DIR_FWD;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
            step_strobe_q  <= 1'b0;
            hall_err_q     <= 1'b0;
            count_q        <= '0;
            last_sector_q  <= SECTOR_NONE;
            prev_step_q    <= 1'b0;
        end else begin
            position_q     <= position_d;
            direction_q    <= direction_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            step_strobe_q  <= step_strobe_d;
            hall_err_q     <= hall_err_d;
            count_q        <= count_d;
            last_sector_q  <= last_sector_d;
            prev_step_q    <= prev_step_d;
        end
    end

    assign position     = position_q;
    assign direction    = direction_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;
    assign step_strobe  = step_strobe_q;
    assign hall_err     = hall_err_q;

endmodule
